// File: rtl/mux_nx_skid_if.sv
// Handshake and data bundle for mux_nx_skid.
// The upstream producer and the downstream consumer share this one bundle.
// The master side drives the selectable inputs and the consumer's ready.
// The slave side (the mux/skid block) returns the buffered result.
interface mux_nx_skid_if #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = 2
);
  logic [INPUTS*WIDTH-1:0] in_bus;
  logic [WIDTH-1:0]        default_in;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_is_default;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_bus, default_in, sel, in_valid, out_ready,
    input  in_ready, out_data, out_is_default, out_valid
  );

  modport slave (
    input  in_bus, default_in, sel, in_valid, out_ready,
    output in_ready, out_data, out_is_default, out_valid
  );
endinterface

// File: rtl/mux_nx_skid.sv
// N-input select mux feeding a registered two-entry skid buffer.
// A select value that is out of range or unknown picks default_in and tags the entry.
// in_ready depends only on the buffer state and flush, so no combinational path runs from out_ready.
module mux_nx_skid #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_nx_skid_if.slave     bus,
  input  logic             flush,
  output logic [CNT_W-1:0] default_count
);

  if (INPUTS < 2 || INPUTS > 16 || (1 << SEL_W) < INPUTS) begin : g_param_error
    $error("mux_nx_skid: illegal INPUTS=%0d with SEL_W=%0d", INPUTS, SEL_W);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              in_fire;
  logic              out_fire;
  logic [31:0]       sel_ext;
  logic [WIDTH-1:0]  sel_value;
  logic              sel_tag;
  logic [WIDTH-1:0]  main_data;
  logic              main_tag;
  logic [WIDTH-1:0]  skid_data;
  logic              skid_tag;
  logic [CNT_W-1:0]  count_q;

  assign bus.in_ready       = (state_q != FULL) & ~flush;
  assign bus.out_valid      = (state_q != EMPTY);
  assign bus.out_data       = main_data;
  assign bus.out_is_default = main_tag;
  assign default_count      = count_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Pick the addressed slice; nothing matches an out-of-range or unknown select, so default_in wins.
  always_comb begin
    sel_ext   = 32'(bus.sel);
    sel_value = bus.default_in;
    sel_tag   = 1'b1;
    for (int i = 0; i < INPUTS; i++) begin
      if (sel_ext == 32'(i)) begin
        sel_value = bus.in_bus[i*WIDTH +: WIDTH];
        sel_tag   = 1'b0;
      end
    end
  end

  // Buffer occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and register load strobes; flush overrides everything and empties the buffer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main entry: drives the output and is refilled from the input or from the older skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_tag  <= 1'b0;
    end else if (load_main_in) begin
      main_data <= sel_value;
      main_tag  <= sel_tag;
    end else if (load_main_skid) begin
      main_data <= skid_data;
      main_tag  <= skid_tag;
    end
  end

  // Skid entry: catches the one input that arrives while the main entry is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
      skid_tag  <= 1'b0;
    end else if (load_skid) begin
      skid_data <= sel_value;
      skid_tag  <= sel_tag;
    end
  end

  // Saturating count of accepted transfers that took the default value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (in_fire && sel_tag && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_nx_skid.sv
// Directed bench for mux_nx_skid: a vector table plus hand-built corner sequences.
// The bench uses a three-input instance with a two-bit counter so the default and saturation paths are reachable.
module tb_mux_nx_skid;
  localparam int WIDTH  = 16;
  localparam int INPUTS = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 2;

  localparam logic [INPUTS*WIDTH-1:0] BUS_A = {16'h0030, 16'h0020, 16'h0010};
  localparam logic [INPUTS*WIDTH-1:0] BUS_B = {16'h0033, 16'h0022, 16'h0011};

  typedef struct {
    logic [SEL_W-1:0]        sel;
    logic [INPUTS*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]        dflt;
    logic                    valid;
    logic                    ordy;
    logic                    fl;
    logic                    exp_ir;
    logic                    exp_ov;
    logic [WIDTH-1:0]        exp_data;
    logic                    exp_def;
    logic [CNT_W-1:0]        exp_cnt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] default_count;
  int               compared   = 0;
  int               mismatched = 0;
  vec_t             vecs[16];
  vec_t             v;

  mux_nx_skid_if #(.WIDTH(WIDTH), .INPUTS(INPUTS), .SEL_W(SEL_W)) bus_if ();

  mux_nx_skid #(.WIDTH(WIDTH), .INPUTS(INPUTS), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .flush         (flush),
    .default_count (default_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    bus_if.sel        = s.sel;
    bus_if.in_bus     = s.in_bus;
    bus_if.default_in = s.dflt;
    bus_if.in_valid   = s.valid;
    bus_if.out_ready  = s.ordy;
    flush             = s.fl;
  endtask

  // Drive one vector for one cycle: in_ready is checked before the edge, registered outputs after it.
  task automatic runVector(input string tag, input vec_t s);
    applyStimulus(s);
    #1;
    checkOutput({tag, " in_ready"}, 32'(bus_if.in_ready), 32'(s.exp_ir));
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid"}, 32'(bus_if.out_valid), 32'(s.exp_ov));
    if (s.exp_ov) begin
      checkOutput({tag, " out_data"}, 32'(bus_if.out_data), 32'(s.exp_data));
      checkOutput({tag, " out_is_default"}, 32'(bus_if.out_is_default), 32'(s.exp_def));
    end
    checkOutput({tag, " default_count"}, 32'(default_count), 32'(s.exp_cnt));
  endtask

  // Pulse rst_n low between clock edges and check that the outputs clear without waiting for an edge.
  task automatic asyncReset(input string tag);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    flush            = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, " rst out_valid"}, 32'(bus_if.out_valid), 32'd0);
    checkOutput({tag, " rst out_data"}, 32'(bus_if.out_data), 32'd0);
    checkOutput({tag, " rst out_is_default"}, 32'(bus_if.out_is_default), 32'd0);
    checkOutput({tag, " rst default_count"}, 32'(default_count), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sel, in_bus, dflt, valid, ordy, flush | in_ready, out_valid, out_data, is_default, count
    vecs[0]  = '{2'd2, BUS_A, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 2'd0};
    vecs[1]  = '{2'd3, BUS_A, 16'h0029, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0029, 1'b1, 2'd1};
    vecs[2]  = '{2'd0, BUS_A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd1};
    vecs[3]  = '{2'd0, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 2'd1};
    vecs[4]  = '{2'd1, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 2'd1};
    vecs[5]  = '{2'd2, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 2'd1};
    vecs[6]  = '{2'd2, BUS_B, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b0, 2'd1};
    vecs[7]  = '{2'd0, BUS_B, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd1};
    vecs[8]  = '{2'd0, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 2'd1};
    vecs[9]  = '{2'd1, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 2'd1};
    vecs[10] = '{2'd2, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1};
    vecs[11] = '{2'd2, BUS_B, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd1};
    vecs[12] = '{2'd3, BUS_A, 16'h0029, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0029, 1'b1, 2'd2};
    vecs[13] = '{2'd3, BUS_A, 16'h002a, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h002a, 1'b1, 2'd3};
    vecs[14] = '{2'd3, BUS_A, 16'h002b, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h002b, 1'b1, 2'd3};
    vecs[15] = '{2'd0, BUS_A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd3};

    rst_n             = 1'b0;
    flush             = 1'b0;
    bus_if.sel        = '0;
    bus_if.in_bus     = '0;
    bus_if.default_in = '0;
    bus_if.in_valid   = 1'b0;
    bus_if.out_ready  = 1'b0;

    #12;
    checkOutput("reset out_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus_if.out_data), 32'd0);
    checkOutput("reset out_is_default", 32'(bus_if.out_is_default), 32'd0);
    checkOutput("reset default_count", 32'(default_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // An out-of-range select and then an unknown select must both take default_in.
    runVector("dflt3", '{2'd3, BUS_A, 16'h0029, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0029, 1'b1, 2'd1});
    v = '{2'bxx, BUS_A, 16'h002c, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h002c, 1'b1, 2'd2};
    if (!$isunknown(v.sel) && (v.sel < 2'd3)) begin
      // A two-state simulator resolves the x literal to a real index, so expect that slice instead.
      v.exp_data = v.in_bus[int'(v.sel)*WIDTH +: WIDTH];
      v.exp_def  = 1'b0;
      v.exp_cnt  = 2'd1;
    end
    runVector("dfltx", v);
    asyncReset("early");

    for (int i = 0; i < 16; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back stream: one new word per cycle, each visible the cycle after it is accepted.
    for (int i = 0; i < 8; i++) begin
      v.sel      = SEL_W'(i % 3);
      v.in_bus   = {WIDTH'(16'h0300 + i), WIDTH'(16'h0200 + i), WIDTH'(16'h0100 + i)};
      v.dflt     = 16'h00ee;
      v.valid    = 1'b1;
      v.ordy     = 1'b1;
      v.fl       = 1'b0;
      v.exp_ir   = 1'b1;
      v.exp_ov   = 1'b1;
      v.exp_data = WIDTH'(16'h0100 * ((i % 3) + 1) + i);
      v.exp_def  = 1'b0;
      v.exp_cnt  = 2'd3;
      runVector($sformatf("stream%0d", i), v);
    end
    runVector("stream_end", vecs[15]);

    // Fill both entries, then reset mid-operation and confirm both are dropped.
    runVector("fill0", '{2'd3, BUS_B, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b1, 2'd3});
    runVector("fill1", '{2'd0, BUS_B, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b1, 2'd3});
    asyncReset("late");
    runVector("post_rst", '{2'd0, BUS_B, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
